// File: rtl/agv_pkg.sv
// Shared opcode, resume-byte and FSM state definitions for the AGV command scheduler.
package agv_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_FWD   = 3'd1;
  localparam logic [2:0] OP_REV   = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;
  localparam logic [2:0] OP_PICK  = 3'd5;
  localparam logic [2:0] OP_DROP  = 3'd6;
  localparam logic [2:0] OP_ESTOP = 3'd7;

  localparam logic [7:0] RESUME_BYTE = 8'h1F;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HALT} state_t;

  // Only motion/handler opcodes go through the queue; NOP and ESTOP act immediately.
  function automatic logic is_queued_op(logic [2:0] op);
    return (op != OP_NOP) && (op != OP_ESTOP);
  endfunction
endpackage

// File: rtl/agv_cmd_scheduler_if.sv
// Receiver-side and executor-side signals of the command scheduler.
// master: the scheduler itself; slave: the receiver/executor environment.
interface agv_cmd_scheduler_if #(parameter int FIFO_DEPTH = 4);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [2:0]    cmd_op;
  logic [4:0]    cmd_arg;
  logic          cmd_start;
  logic          cmd_done;
  logic          estop;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          timeout_err;

  modport master (
    input  rx_data, rx_valid, cmd_done,
    output cmd_op, cmd_arg, cmd_start, estop, busy, fifo_count, overflow, timeout_err
  );

  modport slave (
    output rx_data, rx_valid, cmd_done,
    input  cmd_op, cmd_arg, cmd_start, estop, busy, fifo_count, overflow, timeout_err
  );
endinterface

// File: rtl/agv_cmd_fifo.sv
// Small synchronous FIFO with first-word fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module agv_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  // Storage array; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/agv_cmd_scheduler.sv
// AGV command scheduler: queues received command bytes and issues them to the executor
// one at a time; ESTOP flushes, aborts and halts until the resume byte arrives.
// Optional feature macro: CMD_TIMEOUT_EN (WAIT time limit with sticky timeout_err).
module agv_cmd_scheduler
  import agv_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  agv_cmd_scheduler_if.master   bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("agv_cmd_scheduler: bad FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  state_t        state, state_n;
  logic [7:0]    head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          estop_req, resume_req, push, pop, flush, drop, timeout_hit;
  logic          start_q, estop_q, busy_q, ovf_q;
  logic [2:0]    op_q;
  logic [4:0]    arg_q;

  agv_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .din(bus.rx_data), .head(head), .full(full), .empty(empty), .count(count)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          terr_q;

  // Counts cycles spent in WAIT; held at zero everywhere else so each entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end

  // A completion arriving on the last allowed cycle beats the timeout.
  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) && !bus.cmd_done;

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst)              terr_q <= 1'b0;
    else if (timeout_hit) terr_q <= 1'b1;
  end
  assign bus.timeout_err = terr_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Event decode: ESTOP (or timeout) overrides issue and enqueue in the same cycle.
  always_comb begin
    estop_req  = bus.rx_valid && (bus.rx_data[7:5] == OP_ESTOP);
    resume_req = bus.rx_valid && (bus.rx_data == RESUME_BYTE);
    flush      = estop_req || timeout_hit;
    pop        = (state == ST_IDLE) && !empty && !flush;
    push       = bus.rx_valid && is_queued_op(bus.rx_data[7:5]) && (state != ST_HALT) && !flush;
    drop       = push && full && !pop;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    if (flush) state_n = ST_HALT;
    else begin
      case (state)
        ST_IDLE: if (!empty)      state_n = ST_WAIT;
        ST_WAIT: if (bus.cmd_done) state_n = ST_IDLE;
        ST_HALT: if (resume_req)  state_n = ST_IDLE;
        default:                  state_n = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Registered executor outputs; status levels follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      op_q    <= '0;
      arg_q   <= '0;
      estop_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= pop;
      if (pop) begin
        op_q  <= head[7:5];
        arg_q <= head[4:0];
      end
      estop_q <= (state_n == ST_HALT);
      busy_q  <= (state_n == ST_WAIT);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign bus.cmd_start  = start_q;
  assign bus.cmd_op     = op_q;
  assign bus.cmd_arg    = arg_q;
  assign bus.estop      = estop_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_agv_cmd_scheduler.sv
// Testbench for agv_cmd_scheduler: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_agv_cmd_scheduler;
  localparam int DEPTH = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 50000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  agv_cmd_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus();
  agv_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of pending bytes plus an execution mode.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  logic [7:0] q[$];
  int         mode = M_IDLE;
  int         waited = 0;
  bit         e_start = 0, e_ovf = 0, e_terr = 0;
  logic [2:0] e_op = 0;
  logic [4:0] e_arg = 0;

  function automatic void model_step(bit r, bit v, logic [7:0] d, bit done);
    logic [2:0] op;
    logic [7:0] h;
    bit         fl, was_halted;
    op = d[7:5];
    if (r) begin
      q.delete(); mode = M_IDLE; waited = 0;
      e_start = 0; e_op = 0; e_arg = 0; e_ovf = 0; e_terr = 0;
      return;
    end
    e_start = 0;
    fl = v && (op == 3'd7);
`ifdef CMD_TIMEOUT_EN
    if (!fl && mode == M_RUN && !done && waited + 1 == TO) begin
      fl = 1; e_terr = 1;
    end
`endif
    if (fl) begin
      q.delete(); mode = M_HALT;
    end else begin
      was_halted = (mode == M_HALT);
      case (mode)
        M_IDLE: if (q.size() > 0) begin
          h = q.pop_front(); e_start = 1; e_op = h[7:5]; e_arg = h[4:0];
          mode = M_RUN; waited = 0;
        end
        M_RUN:  if (done) mode = M_IDLE; else waited++;
        default: if (v && d == 8'h1F) mode = M_IDLE;
      endcase
      if (v && !was_halted && op != 3'd0) begin
        if (q.size() < DEPTH) q.push_back(d);
        else e_ovf = 1;
      end
    end
  endfunction

  // One clock cycle: drive inputs, step model at the edge, return at the following negedge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit done);
    bus.rx_valid = v; bus.rx_data = d; bus.cmd_done = done;
    @(posedge clk);
    model_step(rst, v, d, done);
    @(negedge clk);
    bus.rx_valid = 0; bus.cmd_done = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(0, 8'h00, 0); cyc(0, 8'h00, 0); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.estop, bus.busy, bus.fifo_count, bus.overflow, bus.timeout_err} !== 16'h0) begin
      $display("FAIL reset_outputs: got %h want 0000",
        {bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.estop, bus.busy, bus.fifo_count, bus.overflow, bus.timeout_err});
    end else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, 8'h23, 0);
    n_checks++;
    if (bus.cmd_start !== 1'b0) $display("FAIL single_n1_nostart: got %b want 0", bus.cmd_start);
    else n_pass++;
    cyc(0, 8'h00, 0);
    n_checks++;
    if ({bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.busy} !== {1'b1, 3'd1, 5'd3, 1'b1})
      $display("FAIL single_issue: got %b %h %h %b want 1 1 03 1", bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.busy);
    else n_pass++;
    for (int i = 0; i < 9; i++) cyc(0, 8'h00, 0);
    n_checks++;
    if ({bus.cmd_start, bus.busy} !== 2'b01) $display("FAIL single_holding: got %b%b want 01", bus.cmd_start, bus.busy);
    else n_pass++;
    cyc(0, 8'h00, 1);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL single_done_busy: got %b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b[4];
    exp_b = '{8'h42, 8'h63, 8'h84, 8'hA5};
    do_reset();
    cyc(1, 8'h21, 0); cyc(0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc(1, exp_b[i], 0);
    n_checks++;
    if ({bus.fifo_count, bus.overflow} !== {3'd4, 1'b0})
      $display("FAIL ovf_fill: got count=%0d ovf=%b want 4 0", bus.fifo_count, bus.overflow);
    else n_pass++;
    cyc(1, 8'hC1, 0);
    n_checks++;
    if ({bus.fifo_count, bus.overflow} !== {3'd4, 1'b1})
      $display("FAIL ovf_drop: got count=%0d ovf=%b want 4 1", bus.fifo_count, bus.overflow);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1);
      cyc(0, 8'h00, 0);
      n_checks++;
      if ({bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.fifo_count} !== {1'b1, exp_b[i], 3'(3 - i)})
        $display("FAIL ovf_drain_%0d: got %b %h %h cnt=%0d want 1 %h", i, bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.fifo_count, exp_b[i]);
      else n_pass++;
    end
    cyc(0, 8'h00, 1);
  endtask

  task automatic test_estop();
    do_reset();
    cyc(1, 8'h21, 0); cyc(0, 8'h00, 0);
    cyc(1, 8'h42, 0); cyc(1, 8'h63, 0); cyc(1, 8'h84, 0);
    n_checks++;
    if (bus.fifo_count !== 3'd3) $display("FAIL estop_pre_count: got %0d want 3", bus.fifo_count);
    else n_pass++;
    cyc(1, 8'hE0, 0);
    n_checks++;
    if ({bus.estop, bus.busy, bus.cmd_start, bus.fifo_count} !== {3'b100, 3'd0})
      $display("FAIL estop_enter: got estop=%b busy=%b start=%b cnt=%0d want 1 0 0 0", bus.estop, bus.busy, bus.cmd_start, bus.fifo_count);
    else n_pass++;
    cyc(1, 8'h21, 0);
    n_checks++;
    if ({bus.estop, bus.fifo_count, bus.overflow} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL estop_drop: got estop=%b cnt=%0d ovf=%b want 1 0 0", bus.estop, bus.fifo_count, bus.overflow);
    else n_pass++;
    cyc(1, 8'h00, 0);
    n_checks++;
    if (bus.estop !== 1'b1) $display("FAIL estop_plain_nop: got %b want 1", bus.estop);
    else n_pass++;
    cyc(1, 8'h1F, 0);
    n_checks++;
    if ({bus.estop, bus.busy, bus.cmd_start} !== 3'b000)
      $display("FAIL estop_resume: got estop=%b busy=%b start=%b want 000", bus.estop, bus.busy, bus.cmd_start);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 8'h00, 0);
      n_checks++;
      if (bus.cmd_start !== 1'b0) $display("FAIL estop_no_start_%0d: got %b want 0", i, bus.cmd_start);
      else n_pass++;
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    cyc(1, 8'h21, 0); cyc(0, 8'h00, 0);
    cyc(1, 8'h42, 0); cyc(1, 8'h63, 0); cyc(1, 8'h84, 0); cyc(1, 8'hA5, 0);
    cyc(0, 8'h00, 1);
    cyc(1, 8'h62, 0);
    n_checks++;
    if ({bus.fifo_count, bus.overflow, bus.cmd_start, bus.cmd_op, bus.cmd_arg} !== {3'd4, 1'b0, 1'b1, 8'h42})
      $display("FAIL pushpop_full: got cnt=%0d ovf=%b start=%b op=%h arg=%h want 4 0 1 2 02",
        bus.fifo_count, bus.overflow, bus.cmd_start, bus.cmd_op, bus.cmd_arg);
    else n_pass++;
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cyc(1, 8'h21, 0); cyc(0, 8'h00, 0);
    for (int i = 0; i < 19; i++) cyc(0, 8'h00, 0);
    n_checks++;
    if ({bus.estop, bus.timeout_err, bus.busy} !== 3'b001)
      $display("FAIL timeout_before: got %b%b%b want 001", bus.estop, bus.timeout_err, bus.busy);
    else n_pass++;
    cyc(0, 8'h00, 0);
    n_checks++;
    if ({bus.estop, bus.timeout_err, bus.busy} !== 3'b110)
      $display("FAIL timeout_hit: got %b%b%b want 110", bus.estop, bus.timeout_err, bus.busy);
    else n_pass++;
    do_reset();
    cyc(1, 8'h21, 0); cyc(0, 8'h00, 0);
    for (int i = 0; i < 19; i++) cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    n_checks++;
    if ({bus.estop, bus.timeout_err, bus.busy} !== 3'b000)
      $display("FAIL timeout_done_wins: got %b%b%b want 000", bus.estop, bus.timeout_err, bus.busy);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 8'h21, 0); cyc(0, 8'h00, 0); cyc(1, 8'h42, 0); cyc(1, 8'h63, 0);
    rst = 1; cyc(0, 8'h00, 0); rst = 0;
    n_checks++;
    if ({bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.estop, bus.busy, bus.fifo_count, bus.overflow, bus.timeout_err} !== 16'h0)
      $display("FAIL reset_mid: got %h want 0000",
        {bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.estop, bus.busy, bus.fifo_count, bus.overflow, bus.timeout_err});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0);
      n_checks++;
      if (bus.cmd_start !== 1'b0) $display("FAIL reset_mid_quiet_%0d: got %b want 0", i, bus.cmd_start);
      else n_pass++;
    end
    cyc(1, 8'h45, 0); cyc(0, 8'h00, 0);
    n_checks++;
    if ({bus.cmd_start, bus.cmd_op, bus.cmd_arg} !== {1'b1, 8'h45})
      $display("FAIL reset_mid_new: got %b %h %h want 1 2 05", bus.cmd_start, bus.cmd_op, bus.cmd_arg);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic [7:0]  d;
    bit          v, done;
    int          errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 99) < 45);
      d = 8'($urandom);
      if (d[7:5] == 3'd7 && $urandom_range(0, 4) != 0) d[7:5] = 3'd1;
      if ($urandom_range(0, 99) < 7) d = 8'h1F;
      done = ($urandom_range(0, 99) < (bus.busy ? 20 : 5));
      rst = ($urandom_range(0, 399) == 0);
      cyc(v, d, done);
      rst = 0;
      got = {bus.cmd_start, bus.cmd_op, bus.cmd_arg, bus.estop, bus.busy, bus.fifo_count, bus.overflow, bus.timeout_err};
      exp = {e_start, e_op, e_arg, mode == M_HALT, mode == M_RUN, 3'(q.size()), e_ovf, e_terr};
      n_checks++;
      if (got !== exp) begin
        errs++;
        if (errs <= 10) $display("FAIL random_cycle_%0d: got %h want %h", i, got, exp);
      end else n_pass++;
    end
  endtask

  initial begin
    bus.rx_valid = 0; bus.rx_data = 0; bus.cmd_done = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_estop();
    test_push_pop_full();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end
endmodule
